// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data RAM between the core and IO/DMA ports.
// Optional feature: define DMEM_ARB_ADDR_CHECK_EN to reject misaligned/out-of-range accesses (sticky err).
module dmem_arbiter #(
  parameter int DEPTH     = 102,
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic [31:0] c_rdata,
  output logic        c_rvalid,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic        io_gnt,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  output logic        ram_we,
  output logic [31:0] ram_a,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN_C = 2'd1, OWN_IO = 2'd2} state_t;

  localparam int            CW      = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  if (BURST_MAX < 1 || DEPTH < 1) begin : g_bad_params
    $error("dmem_arbiter: BURST_MAX and DEPTH must both be >= 1");
  end

  state_t        state, state_n;
  logic          last_io;
  logic [CW-1:0] burst_cnt, cnt_adv;
  logic          acc, acc_we, illegal;
  logic [31:0]   acc_addr, acc_wdata;

  assign c_gnt     = (state == OWN_C)  && c_req;
  assign io_gnt    = (state == OWN_IO) && io_req;
  assign acc       = c_gnt | io_gnt;
  assign acc_we    = io_gnt ? io_we    : c_we;
  assign acc_addr  = io_gnt ? io_addr  : c_addr;
  assign acc_wdata = io_gnt ? io_wdata : c_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  assign illegal = acc && ((acc_addr[1:0] != 2'b00) || ({20'd0, acc_addr[13:2]} >= DEPTH_W));
`else
  assign illegal = 1'b0;
`endif

  // Write enable is gated by rst_n so a write presented during reset never reaches the RAM.
  assign ram_we = rst_n & acc & acc_we & ~illegal;
  assign ram_a  = acc ? acc_addr  : '0;
  assign ram_wd = acc ? acc_wdata : '0;
  assign busy   = (state != IDLE);

  assign cnt_adv = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CW'(1);

  always_comb begin
    // NOTE: default assignment first so every path drives state_n and no latch is inferred.
    state_n = state;
    unique case (state)
      IDLE: begin
        if (c_req && (!io_req || last_io)) state_n = OWN_C;
        else if (io_req)                   state_n = OWN_IO;
      end
      OWN_C: begin
        if (!c_req)                          state_n = io_req ? OWN_IO : IDLE;
        else if (io_req && cnt_adv == CNT_MAX) state_n = OWN_IO;
      end
      OWN_IO: begin
        if (!io_req)                        state_n = c_req ? OWN_C : IDLE;
        else if (c_req && cnt_adv == CNT_MAX) state_n = OWN_C;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      last_io   <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        burst_cnt <= '0;
        if (state_n != IDLE) last_io <= (state_n == OWN_IO);
      end else if (acc) begin
        burst_cnt <= cnt_adv;
      end
    end
  end

  // Read data returns one cycle after the access; writes leave rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rdata   <= '0;
      c_rvalid  <= 1'b0;
      io_rdata  <= '0;
      io_rvalid <= 1'b0;
    end else begin
      c_rvalid  <= c_gnt && !c_we;
      io_rvalid <= io_gnt && !io_we;
      if (c_gnt && !c_we)   c_rdata  <= illegal ? '0 : ram_rd;
      if (io_gnt && !io_we) io_rdata <= illegal ? '0 : ram_rd;
    end
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a cycle model.
// Honours DMEM_ARB_ADDR_CHECK_EN when defined for the build.
module tb_dmem_arbiter;

  localparam int DEPTH     = 102;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req, c_we, io_req, io_we;
  logic [31:0] c_addr, c_wdata, io_addr, io_wdata;
  logic        c_gnt, io_gnt, c_rvalid, io_rvalid, ram_we, busy, err;
  logic [31:0] c_rdata, io_rdata, ram_a, ram_wd, ram_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd), .ram_rd(ram_rd),
    .busy(busy), .err(err)
  );

  // Bench-side RAM: combinational read, write on the rising edge.
  logic [31:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = (i == 2) ? 32'hDEADBEEF : 32'(32'hC0DE0000 + i);
    forever begin
      @(posedge clk);
      if (ram_we && int'(ram_a[13:2]) < DEPTH) mem[ram_a[13:2]] <= ram_wd;
    end
  end
  always_comb begin
    ram_rd = '0;
    if (int'(ram_a[13:2]) < DEPTH) ram_rd = mem[ram_a[13:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner 0 = none, 1 = core, 2 = IO.
  logic [31:0] ref_mem [DEPTH];
  int          m_owner, m_last, m_cnt;
  logic        exp_c_rv, exp_io_rv, exp_err, last_gc, last_gi;
  logic [31:0] exp_c_rd, exp_io_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
`ifdef DMEM_ARB_ADDR_CHECK_EN
    return (a[1:0] == 2'b00) && (int'(a[13:2]) < DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_cnt = 0;
    exp_c_rv = 0; exp_io_rv = 0; exp_c_rd = '0; exp_io_rd = '0; exp_err = 0;
    last_gc = 0; last_gi = 0;
  endtask

  task automatic drive_c(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    c_req = r; c_we = w; c_addr = a; c_wdata = d;
  endtask

  task automatic drive_io(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    io_req = r; io_we = w; io_addr = a; io_wdata = d;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_c_gnt"}, c_gnt, 0);     check({pfx, "_io_gnt"}, io_gnt, 0);
    check({pfx, "_c_rdata"}, c_rdata, 0); check({pfx, "_io_rdata"}, io_rdata, 0);
    check({pfx, "_c_rvalid"}, c_rvalid, 0); check({pfx, "_io_rvalid"}, io_rvalid, 0);
    check({pfx, "_ram_we"}, ram_we, 0);   check({pfx, "_ram_a"}, ram_a, 0);
    check({pfx, "_ram_wd"}, ram_wd, 0);   check({pfx, "_busy"}, busy, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  // One cycle: inputs are already driven after a falling edge; compare, advance model, wait next fall.
  task automatic step();
    logic gc, gi, we;
    logic [31:0] a, wd;
    int nxt, used;
    bit my_req, oth_req;
    #1;
    gc = (m_owner == 1) && c_req;
    gi = (m_owner == 2) && io_req;
    we = 0; a = '0; wd = '0;
    if (gc)      begin we = c_we;  a = c_addr;  wd = c_wdata;  end
    else if (gi) begin we = io_we; a = io_addr; wd = io_wdata; end
    check("c_gnt", c_gnt, gc);        check("io_gnt", io_gnt, gi);
    check("busy", busy, m_owner != 0);
    check("c_rvalid", c_rvalid, exp_c_rv);   check("c_rdata", c_rdata, exp_c_rd);
    check("io_rvalid", io_rvalid, exp_io_rv); check("io_rdata", io_rdata, exp_io_rd);
    check("ram_we", ram_we, (gc || gi) && we && legal(a));
    check("ram_a", ram_a, a);         check("ram_wd", ram_wd, wd);
    check("err", err, exp_err);

    exp_c_rv  = gc && !c_we;
    exp_io_rv = gi && !io_we;
    if (exp_c_rv)  exp_c_rd  = legal(a) ? ref_mem[a[13:2]] : '0;
    if (exp_io_rv) exp_io_rd = legal(a) ? ref_mem[a[13:2]] : '0;
    if ((gc || gi) && !legal(a)) exp_err = 1;
    if ((gc || gi) && we && legal(a)) ref_mem[a[13:2]] = wd;

    if (m_owner == 0) begin
      used = 0;
      if (c_req && io_req) nxt = 3 - m_last;
      else if (c_req)      nxt = 1;
      else if (io_req)     nxt = 2;
      else                 nxt = 0;
    end else begin
      my_req  = (m_owner == 1) ? c_req : io_req;
      oth_req = (m_owner == 1) ? io_req : c_req;
      used    = (m_cnt + 1 > BURST_MAX) ? BURST_MAX : m_cnt + 1;
      if (!my_req)                            nxt = oth_req ? 3 - m_owner : 0;
      else if (oth_req && used >= BURST_MAX)  nxt = 3 - m_owner;
      else                                    nxt = m_owner;
    end
    if (nxt != m_owner) begin
      m_cnt = 0;
      if (nxt != 0) m_last = nxt;
    end else if (m_owner != 0) begin
      m_cnt = used;
    end
    m_owner = nxt;
    last_gc = gc;
    last_gi = gi;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    drive_c(0, 0, '0, '0);
    drive_io(0, 0, '0, '0);
    #1 check_zero("rst");
    @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  initial begin
    int          cg;
    logic [31:0] old12;
    bit          cp, ip, cwe, iwe;
    logic [31:0] ca, cd, ia, id;

    drive_c(0, 0, '0, '0);
    drive_io(0, 0, '0, '0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i == 2) ? 32'hDEADBEEF : 32'(32'hC0DE0000 + i);
    model_reset();

    // Core-only read of word 2.
    apply_reset();
    drive_c(1, 0, 32'h8, '0); step();
    #1 check("rd_gnt_cyc1", c_gnt, 1); check("rd_ram_a_cyc1", ram_a, 32'h8); step();
    drive_c(0, 0, '0, '0);
    #1 check("rd_rvalid_cyc2", c_rvalid, 1); check("rd_rdata_cyc2", c_rdata, 32'hDEADBEEF); step();
    step();

    // Tie-break: core first after reset, then IO at the next tie from IDLE.
    apply_reset();
    drive_c(1, 1, 32'h10, 32'hAAAA0001); drive_io(1, 1, 32'h14, 32'hBBBB0001); step();
    #1 check("tie1_c_gnt", c_gnt, 1); check("tie1_io_gnt", io_gnt, 0); step();
    drive_c(0, 0, '0, '0); drive_io(0, 0, '0, '0); step();
    drive_c(1, 1, 32'h18, 32'hAAAA0002); drive_io(1, 1, 32'h1C, 32'hBBBB0002); step();
    #1 check("tie2_io_gnt", io_gnt, 1); check("tie2_c_gnt", c_gnt, 0); step();
    drive_c(0, 0, '0, '0); drive_io(0, 0, '0, '0); step(); step();

    // Burst limit: core holds req for 10 cycles while IO waits.
    cg = 0;
    for (int i = 0; i < 10; i++) begin
      drive_c(1, 0, 32'(4 * i), '0);
      drive_io(i >= 1, 0, 32'h100, '0);
      #1;
      if (i <= 5 && c_gnt) cg++;
      if (i == 5) check("burst_io_takes_over", io_gnt, 1);
      step();
    end
    check("burst_core_gnts", cg, 4);
    drive_c(0, 0, '0, '0); drive_io(0, 0, '0, '0); step(); step();

    // IO write sequence.
    drive_io(1, 1, 32'h0, 32'h11); step();
    for (int k = 0; k < 3; k++) begin
      drive_io(1, 1, 32'(4 * k), 32'(32'h11 * (k + 1)));
      #1 check("iowr_ram_we", ram_we, 1); check("iowr_ram_a", ram_a, 32'(4 * k));
      check("iowr_ram_wd", ram_wd, 32'(32'h11 * (k + 1))); check("iowr_io_rvalid", io_rvalid, 0);
      step();
    end
    drive_io(0, 0, '0, '0);
    #1 check("iowr_io_rvalid_end", io_rvalid, 0); step(); step();
    check("iowr_mem0", mem[0], 32'h11); check("iowr_mem1", mem[1], 32'h22); check("iowr_mem2", mem[2], 32'h33);

    // Reset during the third of five core writes.
    old12 = mem[12];
    drive_c(1, 1, 32'd40, 32'h50000000); step();
    for (int k = 0; k < 2; k++) begin
      drive_c(1, 1, 32'(40 + 4 * k), 32'(32'h50000000 + k)); step();
    end
    drive_c(1, 1, 32'd48, 32'h50000002);
    rst_n = 0;
    #1 check_zero("midrst");
    @(negedge clk);
    drive_c(0, 0, '0, '0);
    @(negedge clk);
    model_reset();
    rst_n = 1;
    check("midrst_mem10", mem[10], 32'h50000000);
    check("midrst_mem11", mem[11], 32'h50000001);
    check("midrst_mem12", mem[12], old12);
    step();

`ifdef DMEM_ARB_ADDR_CHECK_EN
    // Illegal write to word 102, then a legal read.
    drive_c(1, 1, 32'h198, 32'hBAD0BAD0); step();
    #1 check("ill_gnt", c_gnt, 1); check("ill_ram_we", ram_we, 0); step();
    drive_c(1, 0, 32'h8, '0);
    #1 check("ill_err_set", err, 1); step();
    drive_c(0, 0, '0, '0);
    #1 check("ill_rd_rvalid", c_rvalid, 1); check("ill_rd_rdata", c_rdata, ref_mem[2]); step();
    step(); step();
    check("ill_err_sticky", err, 1);
`endif

    // Random traffic obeying the requester hold rule.
    cp = 0; ip = 0; cwe = 0; iwe = 0; ca = '0; cd = '0; ia = '0; id = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1; cwe = 1'($urandom_range(0, 1));
        ca = 32'($urandom_range(0, DEPTH - 1) * 4); cd = $urandom;
      end
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; iwe = 1'($urandom_range(0, 1));
        ia = 32'($urandom_range(0, DEPTH - 1) * 4); id = $urandom;
      end
      drive_c(cp, cwe, ca, cd);
      drive_io(ip, iwe, ia, id);
      step();
      if (last_gc) cp = 0;
      if (last_gi) ip = 0;
    end
    drive_c(0, 0, '0, '0); drive_io(0, 0, '0, '0);
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single-port data RAM between the processor core and the IO/DMA engine. Both requesters use a req/gnt handshake. The block picks one owner with round-robin priority and a bounded burst length, then drives the RAM's write enable, address and write data from that owner. It registers the RAM's combinational read data back to the owner with a fixed one-cycle latency.

## Interface
- DEPTH, 102: RAM depth in 32-bit words; used by the address check.
- BURST_MAX, 4: maximum consecutive accesses an owner keeps while the other port is waiting; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- c_req  in  1  core access request.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  32  core byte address; word index is addr[13:2].
- c_wdata  in  32  core write data.
- c_gnt  out  1  core access accepted this cycle.
- c_rdata  out  32  core read data, registered.
- c_rvalid  out  1  c_rdata valid, one-cycle pulse.
- io_req, io_we, io_addr, io_wdata, io_gnt, io_rdata, io_rvalid: IO port, same widths and meaning as the core port.
- ram_we  out  1  RAM write enable.
- ram_a  out  32  RAM byte address.
- ram_wd  out  32  RAM write data.
- ram_rd  in  32  RAM combinational read data.
- busy  out  1  state ≠ IDLE.
- err  out  1  sticky address error; constant 0 unless the address check is compiled in.

## Operation
- FSM states: IDLE, OWN_C, OWN_IO. Registers: last_owner (1 bit) and burst_cnt (0..BURST_MAX).
- From IDLE:
  - Only one req high: go to that port's OWN state.
  - Both reqs high: go to the port that is not last_owner.
  - No req: stay in IDLE.
- While in OWN_x:
  - x_gnt = x_req, combinational. The other port's gnt is 0.
  - Each cycle with x_gnt=1 is one access; burst_cnt increments.
- Leaving OWN_x:
  - x_req low, other port requesting: go directly to OWN_other. There is no idle cycle.
  - x_req low, other port idle: go to IDLE.
  - burst_cnt reaches BURST_MAX and other req is high: go to OWN_other, even if x_req is still high.
  - burst_cnt reaches BURST_MAX and other req is low: stay in OWN_x; burst_cnt saturates.
- On every ownership change, last_owner is updated and burst_cnt clears to 0.
- RAM drive:
  - During an access: ram_a = x_addr, ram_wd = x_wdata, ram_we = x_we.
  - Otherwise ram_we=0, ram_a=0, ram_wd=0.
  - ram_we is gated by rst_n.
- Read access: ram_rd is captured into x_rdata at the access edge, and x_rvalid pulses in the next cycle.
- Write access: x_rvalid stays 0 and x_rdata holds its previous value.
- Requester rule: hold req/we/addr/wdata stable until gnt is seen. Each gnt cycle consumes exactly one access; present the next access in the following cycle.

## Timing
- Reset values: state=IDLE, last_owner=IO (the core wins the first tie), burst_cnt=0. All outputs are 0: c_gnt, io_gnt, c_rdata, io_rdata, c_rvalid, io_rvalid, ram_we, ram_a, ram_wd, busy, err.
- Latency from IDLE: req rises in cycle 0 → gnt and RAM access in cycle 1 → rvalid and rdata in cycle 2.
- Back-to-back accesses by the owner: one access per cycle. A read in cycle n gives rvalid in cycle n+1.
- Ownership handover: the old owner's gnt drops and the new owner's gnt rises at the same edge. There is no dead cycle.
- Reset mid-operation:
  - Writes committed at earlier edges stand.
  - A write presented while rst_n is low is not committed.
  - A pending rvalid is cleared.

## Configuration
- DMEM_ARB_ADDR_CHECK_EN defined: an access is illegal if addr[1:0]≠0 or addr[13:2]≥DEPTH.
  - The access still consumes its gnt, but ram_we is forced to 0.
  - A read returns rdata=0 with rvalid asserted.
  - err sets and stays set until reset.
- Not defined: addresses pass through unchecked and err is tied to 0.

## Test plan
- Core-only read: after reset, c_req=1, c_we=0, c_addr=0x8, RAM word 2=0xDEADBEEF → c_gnt in cycle 1, ram_a=0x8, c_rvalid with c_rdata=0xDEADBEEF in cycle 2.
- Tie-break: c_req and io_req rise together in the first cycle after reset → core granted first; at the next simultaneous tie from IDLE, IO is granted.
- Burst limit: BURST_MAX=4, core holds req for 10 cycles, io_req high → core gets exactly 4 gnts, then IO owns the next cycle, with no gap.
- IO write sequence: io writes 0x11, 0x22, 0x33 to 0x0, 0x4, 0x8 → three consecutive ram_we pulses with matching ram_a/ram_wd; io_rvalid stays 0.
- Reset mid-burst: drop rst_n during the third of five core writes → only two writes land, all outputs return to 0, state is IDLE.
- With DMEM_ARB_ADDR_CHECK_EN: core write to 0x198 (word 102) → ram_we=0, err=1 and stays 1; a following legal read still returns correct data.
